fft_frame_arbiter: RTL and testbench



---
 rtl/fft_arb_pkg.sv | 19 +
 rtl/fft_arb_st_if.sv | 24 ++
 rtl/fft_arb_tag_fifo.sv | 69 ++++++
 rtl/fft_frame_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fft_frame_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_arb_pkg.sv
// Shared constants for the FFT frame arbiter.
// State encoding, tag width and error bit positions.
package fft_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY0 = 2'd1;
  localparam logic [1:0] ST_BUSY1 = 2'd2;

  localparam int TAG_W = 1;

  localparam int ERR_S0    = 0;
  localparam int ERR_S1    = 1;
  localparam int ERR_NOTAG = 2;

  function automatic logic [1:0] grant_of(logic [1:0] st);
    return {st == ST_BUSY1, st == ST_BUSY0};
  endfunction

endpackage

// File: rtl/fft_arb_st_if.sv
// Avalon-ST frame bundle used on every arbiter side.
// Width is set per instance (requester vs FFT output).
interface fft_arb_st_if #(
  parameter int W = 16
);

  logic         valid;
  logic         sop;
  logic         eop;
  logic         ready;
  logic [W-1:0] re;
  logic [W-1:0] im;

  modport master (
    output valid, sop, eop, re, im,
    input  ready
  );

  modport slave (
    input  valid, sop, eop, re, im,
    output ready
  );

endinterface

// File: rtl/fft_arb_tag_fifo.sv
// In-order owner tags for frames inside the FFT.
// Head names the consumer of the oldest frame.
module fft_arb_tag_fifo
  import fft_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];

  // Next pointers, count and storage; push+pop keeps occupancy.
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_tag;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Register FIFO state; reset empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Frame-granular sharing of one FFT core by two producers.
// Output frames return to their issuer via the tag FIFO.
module fft_frame_arbiter
  import fft_arb_pkg::*;
#(
  parameter int wData     = 16,
  parameter int wFft      = 28,
  parameter int wPts      = 12,
  parameter int TAG_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  fft_arb_st_if.slave     s0,
  fft_arb_st_if.slave     s1,
  input  logic [wPts-1:0] s0_fftpts,
  input  logic [wPts-1:0] s1_fftpts,
  input  logic            s0_inverse,
  input  logic            s1_inverse,
  fft_arb_st_if.master    f_sink,
  output logic [wPts-1:0] f_fftpts,
  output logic            f_inverse,
  fft_arb_st_if.slave     f_src,
  fft_arb_st_if.master    d0,
  fft_arb_st_if.master    d1,
  output logic [1:0]      grant,
  output logic [2:0]      err
);

  logic [1:0]      state_q, state_d;
  logic            rr_q, rr_d;
  logic [wPts-1:0] pts_q, pts_d;
  logic            inv_q, inv_d;
  logic [2:0]      err_q, err_d;

  logic             q0, q1, win;
  logic             push, pop, drop;
  logic [TAG_W-1:0] push_tag, tag_head;
  logic             tag_full, tag_empty;

  fft_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  assign q0  = s0.valid & s0.sop & ~tag_full;
  assign q1  = s1.valid & s1.sop & ~tag_full;
  // rr_q names the requester that wins a tie.
  assign win = (q0 & q1) ? rr_q : q1;

  assign grant     = grant_of(state_q);
  assign f_fftpts  = pts_q;
  assign f_inverse = inv_q;
  assign err       = err_q;

  // Grant FSM and forward mux onto the FFT sink.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    pts_d        = pts_q;
    inv_d        = inv_q;
    err_d        = err_q;
    push         = 1'b0;
    push_tag     = '0;
    s0.ready     = 1'b0;
    s1.ready     = 1'b0;
    f_sink.valid = 1'b0;
    f_sink.sop   = 1'b0;
    f_sink.eop   = 1'b0;
    f_sink.re    = {wData{1'b0}};
    f_sink.im    = {wData{1'b0}};
    err_d[ERR_NOTAG] = err_q[ERR_NOTAG] | drop;
    unique case (state_q)
      ST_IDLE: begin
        // Stray mid-frame beats are flushed; sop beats wait.
        s0.ready = s0.valid & ~s0.sop;
        s1.ready = s1.valid & ~s1.sop;
        err_d[ERR_S0] = err_q[ERR_S0] | s0.ready;
        err_d[ERR_S1] = err_q[ERR_S1] | s1.ready;
        if (q0 | q1) begin
          state_d  = win ? ST_BUSY1 : ST_BUSY0;
          push     = 1'b1;
          push_tag = win;
          rr_d     = ~win;
          pts_d    = win ? s1_fftpts : s0_fftpts;
          inv_d    = win ? s1_inverse : s0_inverse;
        end
      end
      ST_BUSY0: begin
        f_sink.valid = s0.valid;
        f_sink.sop   = s0.sop;
        f_sink.eop   = s0.eop;
        f_sink.re    = s0.re;
        f_sink.im    = s0.im;
        s0.ready     = f_sink.ready;
        if (s0.valid & f_sink.ready & s0.eop) state_d = ST_IDLE;
      end
      ST_BUSY1: begin
        f_sink.valid = s1.valid;
        f_sink.sop   = s1.sop;
        f_sink.eop   = s1.eop;
        f_sink.re    = s1.re;
        f_sink.im    = s1.im;
        s1.ready     = f_sink.ready;
        if (s1.valid & f_sink.ready & s1.eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return mux: the oldest tag picks the consumer.
  always_comb begin
    d0.valid    = 1'b0;
    d0.sop      = 1'b0;
    d0.eop      = 1'b0;
    d0.re       = {wFft{1'b0}};
    d0.im       = {wFft{1'b0}};
    d1.valid    = 1'b0;
    d1.sop      = 1'b0;
    d1.eop      = 1'b0;
    d1.re       = {wFft{1'b0}};
    d1.im       = {wFft{1'b0}};
    f_src.ready = 1'b1;
    drop        = 1'b0;
    unique case (1'b1)
      tag_empty: drop = f_src.valid;
      (~tag_empty & (tag_head == 1'b0)): begin
        d0.valid    = f_src.valid;
        d0.sop      = f_src.sop;
        d0.eop      = f_src.eop;
        d0.re       = f_src.re;
        d0.im       = f_src.im;
        f_src.ready = d0.ready;
      end
      (~tag_empty & (tag_head == 1'b1)): begin
        d1.valid    = f_src.valid;
        d1.sop      = f_src.sop;
        d1.eop      = f_src.eop;
        d1.re       = f_src.re;
        d1.im       = f_src.im;
        f_src.ready = d1.ready;
      end
    endcase
    pop = ~tag_empty & f_src.valid & f_src.ready & f_src.eop;
  end

  // Arbiter registers; reset aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      pts_q   <= '0;
      inv_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pts_q   <= pts_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Scoreboard bench for fft_frame_arbiter.
// Producers push expectations; monitors pop and compare.
module tb_fft_frame_arbiter;
  import fft_arb_pkg::*;

  localparam int WD = 16;
  localparam int WF = 28;
  localparam int WP = 12;
  localparam int TD = 4;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [WD-1:0] re;
    logic [WD-1:0] im;
  } sbeat_t;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [WF-1:0] re;
    logic [WF-1:0] im;
  } beat_t;

  typedef struct packed {
    logic [WP-1:0] pts;
    logic          inv;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_arb_st_if #(.W(WD)) s0_if (), s1_if (), fs_if ();
  fft_arb_st_if #(.W(WF)) fr_if (), d0_if (), d1_if ();

  logic [WP-1:0] s0_pts, s1_pts, f_pts;
  logic          s0_inv, s1_inv, f_inv;
  logic [1:0]    grant;
  logic [2:0]    err;

  fft_frame_arbiter #(
    .wData(WD), .wFft(WF), .wPts(WP), .TAG_DEPTH(TD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s0         (s0_if),
    .s1         (s1_if),
    .s0_fftpts  (s0_pts),
    .s1_fftpts  (s1_pts),
    .s0_inverse (s0_inv),
    .s1_inverse (s1_inv),
    .f_sink     (fs_if),
    .f_fftpts   (f_pts),
    .f_inverse  (f_inv),
    .f_src      (fr_if),
    .d0         (d0_if),
    .d1         (d1_if),
    .grant      (grant),
    .err        (err)
  );

  int vec = 0;
  int mis = 0;
  int cyc = 0;
  int dmode = 0;
  logic fft_en = 1'b0;
  logic fft_hold = 1'b0;

  beat_t  exp_d0[$], exp_d1[$];
  cfg_t   cfg0[$], cfg1[$];
  int     route_q[$], sop_log[$];
  sbeat_t cur[$], fft_q[$];
  int     fft_rdy[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WF-1:0] sx(input logic [WD-1:0] v);
    return {{(WF-WD){v[WD-1]}}, v};
  endfunction

  function automatic logic rdy(input int n);
    return (n == 0) ? s0_if.ready : s1_if.ready;
  endfunction

  task automatic drive(input int n, input logic v, input sbeat_t b);
    if (n == 0) begin
      s0_if.valid = v; s0_if.sop = b.sop; s0_if.eop = b.eop;
      s0_if.re = b.re; s0_if.im = b.im;
    end else begin
      s1_if.valid = v; s1_if.sop = b.sop; s1_if.eop = b.eop;
      s1_if.re = b.re; s1_if.im = b.im;
    end
  endtask

  // One frame from requester n; caller is at posedge+1.
  task automatic send_frame(input int n, input int len,
                            input logic [WP-1:0] pts, input logic inv,
                            input int gap);
    cfg_t c;
    sbeat_t b;
    beat_t e;
    c.pts = pts;
    c.inv = inv;
    if (n == 0) begin
      cfg0.push_back(c); s0_pts = pts; s0_inv = inv;
    end else begin
      cfg1.push_back(c); s1_pts = pts; s1_inv = inv;
    end
    for (int i = 0; i < len; i++) begin
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      b.re  = WD'($urandom);
      b.im  = WD'($urandom);
      b.im[WD-1] = n[0];
      if (gap > 0) repeat ($urandom_range(gap)) tick();
      drive(n, 1'b1, b);
      do @(negedge clk); while (!rdy(n));
      e.sop = b.sop; e.eop = b.eop;
      e.re = sx(b.re); e.im = sx(b.im);
      if (n == 0) exp_d0.push_back(e);
      else exp_d1.push_back(e);
      tick();
      drive(n, 1'b0, b);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_d0.size() != 0 || exp_d1.size() != 0 ||
            fft_q.size() != 0 || route_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk(nm, 64'(n < 3000), 64'(1));
  endtask

  // Downstream ready patterns.
  initial begin
    fs_if.ready = 1'b1;
    d0_if.ready = 1'b1;
    d1_if.ready = 1'b1;
    forever begin
      tick();
      fs_if.ready = (dmode == 1) ? ($urandom_range(3) != 0) : 1'b1;
      d0_if.ready = (dmode == 1) ? ($urandom_range(1) == 1) : (dmode == 0);
      d1_if.ready = (dmode == 1) ? ($urandom_range(1) == 1) : (dmode == 0);
    end
  end

  // FFT core model, input side: collect frames, check config.
  sbeat_t mb;
  int     mn;
  cfg_t   mc;
  always @(negedge clk) begin
    if (!rst && fs_if.valid && fs_if.ready) begin
      mb = {fs_if.sop, fs_if.eop, fs_if.re, fs_if.im};
      if (mb.sop) begin
        mn = int'(mb.im[WD-1]);
        sop_log.push_back(mn);
        route_q.push_back(mn);
        chk("grant_at_sop", 64'(grant), 64'((mn == 0) ? 1 : 2));
        if ((mn == 0 && cfg0.size() == 0) || (mn == 1 && cfg1.size() == 0)) begin
          vec++; mis++;
          $display("FAIL cfg_avail: got frame from s%0d expected none", mn);
        end else begin
          mc = (mn == 0) ? cfg0.pop_front() : cfg1.pop_front();
          chk("f_fftpts", 64'(f_pts), 64'(mc.pts));
          chk("f_inverse", 64'(f_inv), 64'(mc.inv));
        end
      end
      cur.push_back(mb);
      if (mb.eop) begin
        foreach (cur[i]) fft_q.push_back(cur[i]);
        fft_rdy.push_back(cyc + int'($urandom_range(8)));
        cur.delete();
      end
    end
  end

  // FFT core model, output side: replay frames in order.
  initial begin
    logic acc;
    sbeat_t hb;
    fr_if.valid = 1'b0; fr_if.sop = 1'b0; fr_if.eop = 1'b0;
    fr_if.re = '0; fr_if.im = '0;
    forever begin
      @(negedge clk);
      acc = fr_if.valid & fr_if.ready & fft_en & !rst;
      tick();
      if (acc) begin
        if (fr_if.eop) void'(fft_rdy.pop_front());
        void'(fft_q.pop_front());
        fr_if.valid = 1'b0;
      end
      if (fft_en && !fr_if.valid && fft_q.size() > 0 &&
          fft_rdy.size() > 0 && !fft_hold && cyc >= fft_rdy[0] &&
          (dmode != 1 || $urandom_range(3) != 0)) begin
        hb = fft_q[0];
        fr_if.valid = 1'b1;
        fr_if.sop = hb.sop; fr_if.eop = hb.eop;
        fr_if.re = sx(hb.re); fr_if.im = sx(hb.im);
      end
    end
  end

  task automatic check_d(input int n, input beat_t got);
    beat_t e;
    int r;
    if ((n == 0 && exp_d0.size() == 0) || (n == 1 && exp_d1.size() == 0)) begin
      vec++; mis++;
      $display("FAIL d%0d_beat: got %0h expected no beat", n, got);
      return;
    end
    e = (n == 0) ? exp_d0.pop_front() : exp_d1.pop_front();
    chk((n == 0) ? "d0_beat" : "d1_beat", 64'(got), 64'(e));
    if (got.eop) begin
      if (route_q.size() == 0) begin
        vec++; mis++;
        $display("FAIL d_route: got eop on d%0d expected none", n);
      end else begin
        r = route_q.pop_front();
        chk("d_route", 64'(n), 64'(r));
      end
    end
  endtask

  // Consumer monitors.
  always @(negedge clk) begin
    if (!rst) begin
      if (d0_if.valid || d1_if.valid)
        chk("d_exclusive", 64'(d0_if.valid & d1_if.valid), 64'(0));
      if (d0_if.valid && d0_if.ready)
        check_d(0, {d0_if.sop, d0_if.eop, d0_if.re, d0_if.im});
      if (d1_if.valid && d1_if.ready)
        check_d(1, {d1_if.sop, d1_if.eop, d1_if.re, d1_if.im});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    sbeat_t z;
    int k;
    int exp_order[3];
    z = '0;
    drive(0, 1'b0, z);
    drive(1, 1'b0, z);
    s0_pts = '0; s1_pts = '0; s0_inv = 1'b0; s1_inv = 1'b0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_s0_ready", 64'(s0_if.ready), 64'(0));
    chk("rst_s1_ready", 64'(s1_if.ready), 64'(0));
    chk("rst_fsink_valid", 64'(fs_if.valid), 64'(0));
    chk("rst_d0_valid", 64'(d0_if.valid), 64'(0));
    chk("rst_d1_valid", 64'(d1_if.valid), 64'(0));
    chk("rst_fftpts", 64'(f_pts), 64'(0));
    chk("rst_inverse", 64'(f_inv), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    tick();
    rst = 1'b0;
    fft_en = 1'b1;
    tick();

    // Collision: s0, then s1 at eop+2, then s1 beats s0.
    fork
      begin
        send_frame(0, 4, 12'd32, 1'b0, 0);
        fork
          send_frame(0, 3, 12'd64, 1'b1, 0);
          begin
            @(negedge clk);
            chk("rr_gap_grant", 64'(grant), 64'(0));
            @(negedge clk);
            chk("rr_s1_grant", 64'(grant), 64'(2));
          end
        join
      end
      send_frame(1, 4, 12'd128, 1'b1, 0);
    join
    drain("drain_collision");
    chk("order_len", 64'(sop_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < sop_log.size(); i++)
      chk("rr_order", 64'(sop_log[i]), 64'(exp_order[i]));

    // Single 8-beat frame on s0.
    send_frame(0, 8, 12'd8, 1'b0, 0);
    @(negedge clk);
    chk("eop_grant_idle", 64'(grant), 64'(0));
    tick();
    drain("drain_single");

    // Tag FIFO full holds the fifth sop.
    fft_hold = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(i % 2, 3, 12'd16, 1'b0, 0);
    fork
      send_frame(0, 3, 12'd16, 1'b0, 0);
      begin
        repeat (8) @(negedge clk);
        chk("full_grant", 64'(grant), 64'(0));
        chk("full_s0_ready", 64'(s0_if.ready), 64'(0));
        fft_hold = 1'b0;
      end
    join
    drain("drain_full");

    // Stray beats and tagless FFT output.
    fft_en = 1'b0;
    s1_if.valid = 1'b1; s1_if.sop = 1'b0; s1_if.eop = 1'b0;
    @(negedge clk);
    chk("stray_s1_ready", 64'(s1_if.ready), 64'(1));
    tick();
    s1_if.valid = 1'b0;
    @(negedge clk);
    chk("err_s1", 64'(err), 64'(3'b010));
    tick();
    fr_if.valid = 1'b1; fr_if.sop = 1'b1; fr_if.eop = 1'b1;
    @(negedge clk);
    chk("notag_ready", 64'(fr_if.ready), 64'(1));
    tick();
    fr_if.valid = 1'b0;
    @(negedge clk);
    chk("err_notag", 64'(err), 64'(3'b110));
    tick();
    fft_en = 1'b1;

    // Reset in the middle of an s0 frame.
    begin
      cfg_t c;
      c.pts = 12'd8; c.inv = 1'b1;
      cfg0.push_back(c);
    end
    s0_pts = 12'd8; s0_inv = 1'b1;
    s0_if.valid = 1'b1; s0_if.sop = 1'b1; s0_if.eop = 1'b0;
    s0_if.re = 16'h1111; s0_if.im = 16'h0222;
    k = 0;
    do begin @(negedge clk); k++; end while (!s0_if.ready && k < 10);
    chk("mid_granted", 64'(s0_if.ready), 64'(1));
    tick();
    s0_if.sop = 1'b0;
    @(negedge clk);
    tick();
    dmode = 2;
    rst = 1'b1;
    s0_if.valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mid_grant", 64'(grant), 64'(0));
    chk("mid_s0_ready", 64'(s0_if.ready), 64'(0));
    chk("mid_s1_ready", 64'(s1_if.ready), 64'(0));
    chk("mid_fsink_valid", 64'(fs_if.valid), 64'(0));
    chk("mid_d0_valid", 64'(d0_if.valid), 64'(0));
    chk("mid_d1_valid", 64'(d1_if.valid), 64'(0));
    chk("mid_fftpts", 64'(f_pts), 64'(0));
    chk("mid_inverse", 64'(f_inv), 64'(0));
    chk("mid_err", 64'(err), 64'(0));
    chk("mid_fifo_empty", 64'(fr_if.ready), 64'(1));
    tick();
    rst = 1'b0;
    dmode = 0;
    cur.delete();
    route_q.delete();
    sop_log.delete();
    tick();
    send_frame(1, 6, 12'd16, 1'b1, 0);
    drain("drain_after_rst");

    // Randomized traffic with backpressure on all sides.
    dmode = 1;
    fork
      repeat (20) send_frame(0, int'($urandom_range(1, 10)),
                             WP'($urandom), 1'($urandom), 3);
      repeat (20) send_frame(1, int'($urandom_range(1, 10)),
                             WP'($urandom), 1'($urandom), 3);
    join
    drain("drain_random");
    dmode = 0;
    tick();
    chk("final_err", 64'(err), 64'(0));
    chk("final_cur", 64'(cur.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
